// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM encodings and state type.
package fifo_rd_packer_pkg;

  // Legacy-compatible state encodings shared with the other FIFO stages.
  typedef logic state_t;

  localparam state_t ST_FILL = 1'b0;
  localparam state_t ST_HOLD = 1'b1;

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-side consumer of a narrow sync FIFO: pops LANES entries, packs them into one wide
// word and presents it on a valid/ready stream. flush closes a partial word as last.
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned CNT_WIDTH = 3,
  localparam int unsigned OUT_WIDTH = IN_WIDTH * LANES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  input  logic [IN_WIDTH-1:0]  fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [LANES-1:0]     out_keep,
  output logic                 out_last,
  output logic                 busy
);

  localparam int unsigned CntExtW = CNT_WIDTH + 1;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              lane_cnt_q, lane_cnt_d;
  logic                              inflight_q;
  logic                              flush_pend_q, flush_pend_d;
  logic [LANES-1:0][IN_WIDTH-1:0]    lane_q, lane_d;
  logic                              out_valid_q, out_valid_d;
  logic [LANES-1:0]                  out_keep_q, out_keep_d;
  logic                              out_last_q, out_last_d;
  logic [LANES-1:0]                  keep_part;
  logic [CNT_WIDTH:0]                pend_cnt;

  // Pop request: only while filling and with room for captured plus in-flight entries.
  always_comb begin
    pend_cnt   = {1'b0, lane_cnt_q} + CntExtW'(inflight_q);
    fifo_rd_en = (state_q == ST_FILL) & ~fifo_empty & ~flush_pend_q &
                 (pend_cnt < CntExtW'(LANES));
  end

  // Keep mask for a flushed partial word: one bit per captured lane.
  always_comb begin
    keep_part = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      keep_part[i] = (CNT_WIDTH'(i) < lane_cnt_q);
    end
  end

  // Next-state: capture into lanes, close words on fill or flush, release on handshake.
  always_comb begin
    state_d      = state_q;
    lane_cnt_d   = lane_cnt_q;
    lane_d       = lane_q;
    flush_pend_d = flush_pend_q | flush;
    out_valid_d  = out_valid_q;
    out_keep_d   = out_keep_q;
    out_last_d   = out_last_q;
    case (state_q)
      ST_FILL: begin
        if (inflight_q) begin
          for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_cnt_q == CNT_WIDTH'(i)) lane_d[i] = fifo_rd_data;
          end
          lane_cnt_d = lane_cnt_q + CNT_WIDTH'(1);
          if (lane_cnt_q == CNT_WIDTH'(LANES - 1)) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_keep_d  = '1;
            out_last_d  = flush_pend_q | flush;
            // The pending flush is consumed by this word; a flush arriving during HOLD
            // then re-arms cleanly for the next accumulation.
            if (flush_pend_q | flush) flush_pend_d = 1'b0;
          end
        end else if (flush_pend_q) begin
          if (lane_cnt_q != '0) begin
            state_d     = ST_HOLD;
            out_valid_d = 1'b1;
            out_keep_d  = keep_part;
            out_last_d  = 1'b1;
          end
          flush_pend_d = flush;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_FILL;
          out_valid_d = 1'b0;
          out_keep_d  = '0;
          out_last_d  = 1'b0;
          lane_cnt_d  = '0;
          // Cleared lanes make unfilled lanes of a later partial word read as zero.
          lane_d      = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // State registers; reset drops any partially packed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      lane_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      lane_q       <= '0;
      out_valid_q  <= 1'b0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_cnt_q   <= lane_cnt_d;
      inflight_q   <= fifo_rd_en;
      flush_pend_q <= flush_pend_d;
      lane_q       <= lane_d;
      out_valid_q  <= out_valid_d;
      out_keep_q   <= out_keep_d;
      out_last_q   <= out_last_d;
    end
  end

  // Output drive; data is masked to zero whenever no word is presented.
  always_comb begin
    out_valid = out_valid_q;
    out_data  = out_valid_q ? lane_q : '0;
    out_keep  = out_keep_q;
    out_last  = out_last_q;
    busy      = (lane_cnt_q != '0) | inflight_q | out_valid_q | flush_pend_q;
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: behavioural FIFO, scoreboard of expected words,
// table of packing vectors plus hand-written multi-cycle corner cases.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_rd_packer #(
    .IN_WIDTH (8),
    .LANES    (4),
    .CNT_WIDTH(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_keep    (out_keep),
    .out_last    (out_last),
    .busy        (busy)
  );

  // Behavioural FIFO: one-cycle read latency, junk on the data bus when not popping.
  logic [7:0] mem [128];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int rd_pulses = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_cnt];
      rd_cnt       <= rd_cnt + 1;
      rd_pulses    <= rd_pulses + 1;
    end else begin
      fifo_rd_data <= 8'hEE;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          do_flush;
    int          stall;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    logic        exp_last;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_cnt] = b;
    wr_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares every presented word against the scoreboard head; pops on handshake.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_data, 32'hxxxx_xxxx);
        end else begin
          check("word_data", out_data, exp_q[0].data);
          check("word_keep", {28'd0, out_keep}, {28'd0, exp_q[0].keep});
          check("word_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
          check("rd_en_in_hold", {31'd0, fifo_rd_en}, 32'd0);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_in_time", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("valid_in_time", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_empty(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (fifo_empty) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("fifo_drained", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({name, "_data"}, out_data, 32'd0);
    check({name, "_keep"}, {28'd0, out_keep}, 32'd0);
    check({name, "_last"}, {31'd0, out_last}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
  endtask

  initial begin
    int rd_base;

    vecs[0] = '{4, 32'h04030201, 1'b0, 0, 32'h04030201, 4'hF, 1'b0};
    vecs[1] = '{4, 32'h23222120, 1'b0, 3, 32'h23222120, 4'hF, 1'b0};
    vecs[2] = '{2, 32'h9988BBAA, 1'b1, 0, 32'h0000BBAA, 4'h3, 1'b1};
    vecs[3] = '{1, 32'h7766555A, 1'b1, 0, 32'h0000005A, 4'h1, 1'b1};
    vecs[4] = '{3, 32'h44C3C2C1, 1'b1, 2, 32'h00C3C2C1, 4'h7, 1'b1};
    vecs[5] = '{4, 32'hEFBEADDE, 1'b0, 0, 32'hEFBEADDE, 4'hF, 1'b0};
    vecs[6] = '{4, 32'h00FF00FF, 1'b0, 1, 32'h00FF00FF, 4'hF, 1'b0};

    fork
      monitor_loop();
    join_none

    #2;
    check_idle_outputs("reset");
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Table-driven packing vectors, full words and flushed partial words.
    for (int v = 0; v < 7; v++) begin
      rd_base   = rd_pulses;
      out_ready = (vecs[v].stall == 0);
      exp_q.push_back('{vecs[v].exp_data, vecs[v].exp_keep, vecs[v].exp_last});
      for (int i = 0; i < vecs[v].n; i++) begin
        logic [31:0] bw;
        bw = vecs[v].bytes;
        push(bw[8*i +: 8]);
      end
      if (vecs[v].do_flush) begin
        wait_empty(20);
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      if (vecs[v].stall != 0) begin
        wait_valid(30);
        repeat (vecs[v].stall) tick();
        out_ready = 1'b1;
      end
      wait_drain(60);
      check("vec_rd_pulses", rd_pulses - rd_base, vecs[v].n);
      check("vec_busy_idle", {31'd0, busy}, 32'd0);
    end

    // Back-pressure: eight entries queued, first word held for five cycles.
    rd_base   = rd_pulses;
    out_ready = 1'b0;
    exp_q.push_back('{32'h13121110, 4'hF, 1'b0});
    exp_q.push_back('{32'h17161514, 4'hF, 1'b0});
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_valid(30);
    repeat (5) tick();
    check("bp_no_pop_in_hold", rd_pulses - rd_base, 4);
    check("bp_fifo_backed_up", {31'd0, fifo_empty}, 32'd0);
    out_ready = 1'b1;
    wait_drain(60);
    check("bp_rd_pulses", rd_pulses - rd_base, 8);

    // Flush with nothing accumulated: pending flag only, no word.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("empty_flush_busy", {31'd0, busy}, 32'd1);
    tick();
    check("empty_flush_clear", {31'd0, busy}, 32'd0);
    check("empty_flush_novalid", {31'd0, out_valid}, 32'd0);

    // Flush coincident with the capture that fills the word.
    exp_q.push_back('{32'h04030201, 4'hF, 1'b1});
    for (int i = 0; i < 4; i++) push(8'h01 + 8'(i));
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_drain(40);
    exp_q.push_back('{32'h08070605, 4'hF, 1'b0});
    for (int i = 0; i < 4; i++) push(8'h05 + 8'(i));
    wait_drain(40);

    // Asynchronous reset mid-word drops the partial data.
    push(8'h21);
    push(8'h22);
    repeat (5) tick();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back('{32'h08070605, 4'hF, 1'b0});
    for (int i = 0; i < 4; i++) push(8'h05 + 8'(i));
    wait_drain(40);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
